copy_job_scheduler: RTL and testbench

COPY_JOB_SCHEDULER -- requirements
Module: copy_job_scheduler

---
 rtl/copy_job_scheduler_pkg.sv | 27 ++
 rtl/copy_job_scheduler_job_fifo.sv | 43 ++++
 rtl/copy_job_scheduler.sv | 139 +++++++++++++
 tb/tb_copy_job_scheduler.sv | 524 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/copy_job_scheduler_pkg.sv
// Shared constants, sequencer state encoding and queue entry layout for the copy job scheduler.
package copy_job_scheduler_pkg;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned QDEPTH = 4;
  localparam int unsigned AW     = 31;
  localparam int unsigned IDW    = 2;
  localparam int unsigned EW     = IDW + 3 * AW;

  typedef enum logic [2:0] {
    StIdle,
    StLds,
    StLdd,
    StLdl,
    StSettle,
    StWaitc,
    StDone
  } seq_state_e;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [AW-1:0]  src;
    logic [AW-1:0]  dst;
    logic [AW-1:0]  len;
  } job_t;

endpackage

// File: rtl/copy_job_scheduler_job_fifo.sv
// Descriptor queue: synchronous FIFO with wrap-bit pointers; Depth must be a power of two >= 2.
module job_fifo
  import copy_job_scheduler_pkg::*;
#(
  parameter int unsigned Depth = QDEPTH,
  parameter int unsigned Width = EW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]     wptr_q, rptr_q;
  logic [Width-1:0]   mem_q [Depth];

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign data_o  = mem_q[rptr_q[AddrW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o) wptr_q <= wptr_q + 1'b1;
      if (pop_i && !empty_o) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage is left unreset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (push_i && !full_o) mem_q[wptr_q[AddrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/copy_job_scheduler.sv
// Round-robin copy-job arbiter feeding a descriptor queue and a sequencer that loads the copier
// registers (S, D, then L) and reports completion with the copier checksum.
module copy_job_scheduler #(
  parameter int unsigned NREQ   = copy_job_scheduler_pkg::NREQ,
  parameter int unsigned QDEPTH = copy_job_scheduler_pkg::QDEPTH
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic [NREQ-1:0]                            jobValid,
  output logic [NREQ-1:0]                            jobReady,
  input  logic [copy_job_scheduler_pkg::AW*NREQ-1:0] jobSrc,
  input  logic [copy_job_scheduler_pkg::AW*NREQ-1:0] jobDst,
  input  logic [copy_job_scheduler_pkg::AW*NREQ-1:0] jobLen,
  output logic [31:0]                                wq,
  output logic                                       loadS,
  output logic                                       loadD,
  output logic                                       loadL,
  input  logic [16:0]                                copierStatus,
  output logic                                       doneValid,
  output logic [1:0]                                 doneId,
  output logic [15:0]                                doneChecksum
);
  import copy_job_scheduler_pkg::*;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           push, pop, full, empty;
  job_t           push_job, head_job;
  seq_state_e     state_q, state_d;
  logic [IDW-1:0] act_id_q, act_id_d;
  logic [15:0]    chk_q, chk_d;
  logic           busy;

  assign busy = copierStatus[0];

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!gnt_valid && jobValid[(int'(ptr_q) + k) % int'(NREQ)]) begin
        gnt_valid = 1'b1;
        gnt_id    = IDW'((int'(ptr_q) + k) % int'(NREQ));
      end
    end
  end

  // Full refuses a push even if the sequencer pops in the same cycle.
  assign push = gnt_valid && !full && !reset;
  assign ptr_d = push ? gnt_id + 1'b1 : ptr_q;

  always_comb begin
    jobReady = '0;
    if (push) jobReady[gnt_id] = 1'b1;
  end

  assign push_job.id  = gnt_id;
  assign push_job.src = jobSrc[int'(gnt_id)*AW +: AW];
  assign push_job.dst = jobDst[int'(gnt_id)*AW +: AW];
  assign push_job.len = jobLen[int'(gnt_id)*AW +: AW];

  job_fifo #(
    .Depth(QDEPTH),
    .Width(EW)
  ) u_job_fifo (
    .clock  (clock),
    .reset  (reset),
    .push_i (push),
    .data_i (push_job),
    .pop_i  (pop),
    .data_o (head_job),
    .full_o (full),
    .empty_o(empty)
  );

  always_comb begin
    state_d   = state_q;
    act_id_d  = act_id_q;
    chk_d     = chk_q;
    pop       = 1'b0;
    wq        = '0;
    loadS     = 1'b0;
    loadD     = 1'b0;
    loadL     = 1'b0;
    doneValid = 1'b0;
    doneId    = '0;
    unique case (state_q)
      // A push into an empty queue starts loading on the very next cycle.
      StIdle:   if ((!empty || push) && !busy) state_d = StLds;
      StLds: begin
        wq      = {1'b0, head_job.src};
        loadS   = 1'b1;
        state_d = StLdd;
      end
      StLdd: begin
        wq      = {1'b0, head_job.dst};
        loadD   = 1'b1;
        state_d = StLdl;
      end
      StLdl: begin
        wq       = {1'b0, head_job.len};
        loadL    = 1'b1;
        pop      = 1'b1;
        act_id_d = head_job.id;
        state_d  = StSettle;
      end
      StSettle: state_d = StWaitc;
      StWaitc: begin
        if (!busy) begin
          chk_d   = copierStatus[16:1];
          state_d = StDone;
        end
      end
      StDone: begin
        doneValid = 1'b1;
        doneId    = act_id_q;
        state_d   = StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      act_id_q <= '0;
      chk_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      act_id_q <= act_id_d;
      chk_q    <= chk_d;
    end
  end

  assign doneChecksum = chk_q;

endmodule

// File: tb/tb_copy_job_scheduler.sv
// Bench for copy_job_scheduler: directed scenarios plus randomized traffic against a queue model.
module tb_copy_job_scheduler;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic [3:0]   jobValid, jobReady;
  logic [123:0] jobSrc, jobDst, jobLen;
  logic [31:0]  wq;
  logic         loadS, loadD, loadL;
  logic [16:0]  copierStatus;
  logic         doneValid;
  logic [1:0]   doneId;
  logic [15:0]  doneChecksum;

  int errors = 0;
  int checks = 0;

  // Copier model: busy for cop_hold cycles starting the cycle after a nonzero L load.
  logic        force_busy = 1'b0;
  logic [15:0] cop_sum = 16'h0;
  int          cop_hold = 0;
  int          cop_left = 0;

  logic [30:0] ps[4], pd[4], pl[4];

  typedef struct {
    int          id;
    logic [30:0] src, dst, len;
  } job_t;

  always @(posedge clock) begin
    if (reset) cop_left <= 0;
    else if (loadL && wq != 32'd0) cop_left <= cop_hold;
    else if (cop_left > 0) cop_left <= cop_left - 1;
  end

  assign copierStatus = {cop_sum, force_busy | (cop_left != 0)};

  copy_job_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .jobValid    (jobValid),
    .jobReady    (jobReady),
    .jobSrc      (jobSrc),
    .jobDst      (jobDst),
    .jobLen      (jobLen),
    .wq          (wq),
    .loadS       (loadS),
    .loadD       (loadD),
    .loadL       (loadL),
    .copierStatus(copierStatus),
    .doneValid   (doneValid),
    .doneId      (doneId),
    .doneChecksum(doneChecksum)
  );

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic set_job(input int c, input logic [30:0] s, input logic [30:0] d,
                         input logic [30:0] l);
    ps[c] = s;
    pd[c] = d;
    pl[c] = l;
    jobSrc[c*31 +: 31] = s;
    jobDst[c*31 +: 31] = d;
    jobLen[c*31 +: 31] = l;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    jobValid   = '0;
    force_busy = 1'b0;
    cop_hold   = 0;
    nxt();
    reset = 1'b0;
  endtask

  // Round-robin reference: first valid client at or after the priority pointer.
  function automatic int rr_pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) begin
      if (m[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic test_reset();
    reset    = 1'b1;
    jobValid = 4'hF;
    jobSrc   = '0;
    jobDst   = '0;
    jobLen   = '0;
    nxt();
    nxt();
    smp();
    checks++;
    if (jobReady !== 4'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0000", jobReady);
    end
    checks++;
    if ({loadS, loadD, loadL} !== 3'b000 || wq !== 32'h0) begin
      errors++; $display("FAIL reset_loads: got %b wq=%h want 000 wq=0", {loadS, loadD, loadL}, wq);
    end
    checks++;
    if (doneValid !== 1'b0 || doneId !== 2'd0 || doneChecksum !== 16'h0) begin
      errors++;
      $display("FAIL reset_done: got v=%b id=%0d chk=%h want 0/0/0", doneValid, doneId,
               doneChecksum);
    end
    nxt();
    reset    = 1'b0;
    jobValid = '0;
    smp();
    checks++;
    if (jobReady !== 4'b0 || wq !== 32'h0) begin
      errors++; $display("FAIL reset_after: ready=%b wq=%h want 0", jobReady, wq);
    end
  endtask

  task automatic test_single();
    int n;
    bit got, stray;
    do_reset();
    cop_hold = 20;
    cop_sum  = 16'h1234;
    set_job(2, 31'h100, 31'h200, 31'h10);
    jobValid = 4'b0100;
    smp();
    checks++;
    if (jobReady !== 4'b0100) begin
      errors++; $display("FAIL single_grant: got %b want 0100", jobReady);
    end
    nxt();
    jobValid = '0;
    smp();
    checks++;
    if ({loadS, loadD, loadL} !== 3'b100 || wq !== 32'h100) begin
      errors++; $display("FAIL single_lds: got %b wq=%h want 100 wq=100", {loadS, loadD, loadL}, wq);
    end
    nxt();
    smp();
    checks++;
    if ({loadS, loadD, loadL} !== 3'b010 || wq !== 32'h200) begin
      errors++; $display("FAIL single_ldd: got %b wq=%h want 010 wq=200", {loadS, loadD, loadL}, wq);
    end
    nxt();
    smp();
    checks++;
    if ({loadS, loadD, loadL} !== 3'b001 || wq !== 32'h10) begin
      errors++; $display("FAIL single_ldl: got %b wq=%h want 001 wq=10", {loadS, loadD, loadL}, wq);
    end
    n = 0; got = 0; stray = 0;
    while (!got && n < 40) begin
      nxt();
      smp();
      n++;
      if (doneValid) got = 1;
      else if (wq !== 32'h0 || loadS || loadD || loadL) stray = 1;
    end
    checks++;
    if (!got || n != 22) begin
      errors++; $display("FAIL single_done_latency: got done=%0d after %0d want 1 after 22", got, n);
    end
    checks++;
    if (stray) begin
      errors++; $display("FAIL single_idle_outputs: got stray wq/strobe want none");
    end
    checks++;
    if (doneId !== 2'd2 || doneChecksum !== 16'h1234) begin
      errors++; $display("FAIL single_done_data: got id=%0d chk=%h want 2/1234", doneId, doneChecksum);
    end
    nxt();
    smp();
    checks++;
    if (doneValid !== 1'b0) begin
      errors++; $display("FAIL single_done_pulse: got %b want 0", doneValid);
    end
  endtask

  task automatic test_zero_len();
    int n;
    do_reset();
    cop_sum = 16'hFFFF;
    set_job(0, 31'h5, 31'h6, 31'h0);
    jobValid = 4'b0001;
    smp();
    nxt();
    jobValid = '0;
    smp();
    checks++;
    if (loadS !== 1'b1) begin
      errors++; $display("FAIL zero_lds: got %b want 1", loadS);
    end
    n = 0;
    while (n < 10 && doneValid !== 1'b1) begin
      nxt();
      smp();
      n++;
    end
    checks++;
    if (n != 5 || doneChecksum !== 16'hFFFF || doneId !== 2'd0) begin
      errors++;
      $display("FAIL zero_done: got %0d cycles chk=%h id=%0d want 5 FFFF 0", n, doneChecksum, doneId);
    end
  endtask

  task automatic test_busy_held();
    bit early;
    int n;
    do_reset();
    force_busy = 1'b1;
    cop_hold   = 3;
    set_job(3, 31'h7000_0001, 31'h0ABC_DEF0, 31'h3);
    jobValid = 4'b1000;
    smp();
    checks++;
    if (jobReady !== 4'b1000) begin
      errors++; $display("FAIL busy_grant: got %b want 1000", jobReady);
    end
    nxt();
    jobValid = '0;
    early = 0;
    repeat (4) begin
      smp();
      if (loadS) early = 1;
      nxt();
    end
    checks++;
    if (early) begin
      errors++; $display("FAIL busy_hold_idle: got LDS while busy want none");
    end
    force_busy = 1'b0;
    smp();
    checks++;
    if (loadS !== 1'b0) begin
      errors++; $display("FAIL busy_fall_cycle: got loadS=%b want 0", loadS);
    end
    nxt();
    smp();
    checks++;
    if (loadS !== 1'b1 || wq !== 32'h7000_0001) begin
      errors++; $display("FAIL busy_lds_after: got loadS=%b wq=%h want 1 70000001", loadS, wq);
    end
    n = 0;
    while (n < 30 && doneValid !== 1'b1) begin
      nxt();
      smp();
      n++;
    end
    checks++;
    if (doneValid !== 1'b1 || doneId !== 2'd3) begin
      errors++; $display("FAIL busy_done: got v=%b id=%0d want 1 3", doneValid, doneId);
    end
  endtask

  task automatic test_all_four();
    int exp_q[$], gq[$], dq[$];
    logic [3:0] m, seen;
    int p, g, a;
    do_reset();
    cop_hold = 2;
    for (int c = 0; c < 4; c++) set_job(c, 31'(16 * c + 1), 31'(16 * c + 2), 31'(c + 1));
    jobValid = 4'hF;
    m = 4'hF;
    p = 0;
    while (m != 4'h0) begin
      g = rr_pick(m, p);
      exp_q.push_back(g);
      m[g] = 1'b0;
      p = (g + 1) % 4;
    end
    for (int cyc = 0; cyc < 100 && dq.size() < 4; cyc++) begin
      smp();
      for (int i = 0; i < 4; i++) if (jobReady[i]) gq.push_back(i);
      if (doneValid) dq.push_back(int'(doneId));
      seen = jobReady;
      nxt();
      jobValid = jobValid & ~seen;
    end
    for (int i = 0; i < 4; i++) begin
      a = (i < gq.size()) ? gq[i] : -1;
      checks++;
      if (a != exp_q[i]) begin
        errors++; $display("FAIL all4_grant[%0d]: got %0d want %0d", i, a, exp_q[i]);
      end
      a = (i < dq.size()) ? dq[i] : -1;
      checks++;
      if (a != exp_q[i]) begin
        errors++; $display("FAIL all4_done[%0d]: got %0d want %0d", i, a, exp_q[i]);
      end
    end
  endtask

  task automatic test_full();
    int acc, k, nd;
    bit r, found, bad_id;
    do_reset();
    force_busy = 1'b1;
    cop_hold   = 1;
    k = 0;
    set_job(1, 31'h1000, 31'h2000, 31'h1);
    jobValid = 4'b0010;
    acc = 0;
    for (int cyc = 0; cyc < 20 && acc < 4; cyc++) begin
      smp();
      r = jobReady[1];
      nxt();
      if (r) begin
        acc++;
        k++;
        set_job(1, 31'(32'h1000 + k), 31'(32'h2000 + k), 31'(k + 1));
      end
    end
    checks++;
    if (acc != 4) begin
      errors++; $display("FAIL full_accepts: got %0d want 4", acc);
    end
    repeat (3) begin
      smp();
      checks++;
      if (jobReady !== 4'b0) begin
        errors++; $display("FAIL full_hold: got %b want 0000", jobReady);
      end
      nxt();
    end
    force_busy = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      smp();
      if (loadL) begin
        found = 1;
        checks++;
        if (jobReady !== 4'b0) begin
          errors++; $display("FAIL full_pop_cycle: got %b want 0000", jobReady);
        end
      end
      nxt();
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL full_ldl_seen: got none want LDL");
    end
    smp();
    checks++;
    if (jobReady !== 4'b0010) begin
      errors++; $display("FAIL full_reopen: got %b want 0010", jobReady);
    end
    nxt();
    jobValid = '0;
    nd = 0;
    bad_id = 0;
    for (int cyc = 0; cyc < 200 && nd < 5; cyc++) begin
      smp();
      if (doneValid) begin
        nd++;
        if (doneId !== 2'd1) bad_id = 1;
      end
      nxt();
    end
    checks++;
    if (nd != 5 || bad_id) begin
      errors++; $display("FAIL full_dones: got %0d bad_id=%0d want 5 0", nd, bad_id);
    end
  endtask

  task automatic test_reset_mid();
    bit found, seen_done, stray;
    logic [3:0] seen;
    do_reset();
    cop_hold = 30;
    set_job(0, 31'h11, 31'h21, 31'h31);
    set_job(1, 31'h12, 31'h22, 31'h32);
    set_job(2, 31'h13, 31'h23, 31'h33);
    jobValid = 4'b0111;
    found = 0;
    seen_done = 0;
    for (int cyc = 0; cyc < 60 && !found; cyc++) begin
      smp();
      if (doneValid) seen_done = 1;
      if (loadL) found = 1;
      seen = jobReady;
      nxt();
      jobValid = jobValid & ~seen;
    end
    nxt();
    reset = 1'b1;
    smp();
    if (doneValid) seen_done = 1;
    nxt();
    reset = 1'b0;
    smp();
    checks++;
    if (!found || seen_done || doneValid !== 1'b0) begin
      errors++; $display("FAIL midrst_no_done: got ldl=%0d done=%0d want 1 0", found, seen_done);
    end
    checks++;
    if (jobReady !== 4'b0 || {loadS, loadD, loadL} !== 3'b0 || wq !== 32'h0 ||
        doneId !== 2'd0 || doneChecksum !== 16'h0) begin
      errors++;
      $display("FAIL midrst_outputs: got ready=%b ld=%b wq=%h id=%0d chk=%h want all 0", jobReady,
               {loadS, loadD, loadL}, wq, doneId, doneChecksum);
    end
    stray = 0;
    repeat (12) begin
      nxt();
      smp();
      if (loadS || doneValid) stray = 1;
    end
    checks++;
    if (stray) begin
      errors++; $display("FAIL midrst_queue_empty: got activity want none");
    end
  endtask

  task automatic test_random();
    job_t        mq[$], fl[$], j;
    logic [15:0] sums[$], s;
    logic [3:0]  exp_rdy, seen;
    int          mptr, g, ph;
    bit          drain, ok;
    do_reset();
    mptr = 0;
    ph   = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      drain = (cyc >= 500);
      if (drain && jobValid == 4'h0 && mq.size() == 0 && fl.size() == 0 && ph == 0) break;
      smp();
      g = rr_pick(jobValid, mptr);
      exp_rdy = (g >= 0 && mq.size() < 4) ? 4'(1 << g) : 4'b0;
      checks++;
      if (jobReady !== exp_rdy) begin
        errors++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, jobReady, exp_rdy);
      end
      if (ph == 1) begin
        checks++;
        if ({loadS, loadD, loadL} !== 3'b010 || wq !== {1'b0, mq[0].dst}) begin
          errors++; $display("FAIL rand_ldd@%0d: got %b wq=%h want 010 %h", cyc,
                             {loadS, loadD, loadL}, wq, {1'b0, mq[0].dst});
        end
        ph = 2;
      end else if (ph == 2) begin
        checks++;
        if ({loadS, loadD, loadL} !== 3'b001 || wq !== {1'b0, mq[0].len}) begin
          errors++; $display("FAIL rand_ldl@%0d: got %b wq=%h want 001 %h", cyc,
                             {loadS, loadD, loadL}, wq, {1'b0, mq[0].len});
        end
        fl.push_back(mq.pop_front());
        cop_sum = 16'($urandom);
        sums.push_back(cop_sum);
        ph = 0;
      end else if (loadS || loadD || loadL) begin
        ok = loadS && !loadD && !loadL && mq.size() > 0 && fl.size() == 0;
        if (ok) ok = (wq === {1'b0, mq[0].src});
        checks++;
        if (!ok) begin
          errors++; $display("FAIL rand_lds@%0d: got ld=%b wq=%h queued=%0d inflight=%0d", cyc,
                             {loadS, loadD, loadL}, wq, mq.size(), fl.size());
        end
        ph = 1;
      end else begin
        checks++;
        if (wq !== 32'h0) begin
          errors++; $display("FAIL rand_wq_idle@%0d: got %h want 0", cyc, wq);
        end
      end
      if (doneValid) begin
        checks++;
        if (fl.size() == 0) begin
          errors++; $display("FAIL rand_done@%0d: got unexpected done want none", cyc);
        end else begin
          j = fl.pop_front();
          s = sums.pop_front();
          if (doneId !== 2'(j.id) || doneChecksum !== s) begin
            errors++; $display("FAIL rand_done@%0d: got id=%0d chk=%h want %0d %h", cyc, doneId,
                               doneChecksum, j.id, s);
          end
        end
      end
      if (exp_rdy != 4'b0) begin
        j = '{g, ps[g], pd[g], pl[g]};
        mq.push_back(j);
        mptr = (g + 1) % 4;
      end
      seen = jobReady & jobValid;
      nxt();
      cop_hold = $urandom_range(0, 4);
      for (int i = 0; i < 4; i++) begin
        if (seen[i]) jobValid[i] = 1'b0;
        if (!jobValid[i] && !drain && $urandom_range(0, 2) == 0) begin
          set_job(i, 31'($urandom), 31'($urandom),
                  ($urandom_range(0, 3) == 0) ? 31'h0 : 31'($urandom));
          jobValid[i] = 1'b1;
        end
      end
    end
    checks++;
    if (mq.size() != 0 || fl.size() != 0 || jobValid != 4'h0) begin
      errors++; $display("FAIL rand_drain: got queued=%0d inflight=%0d want 0 0", mq.size(),
                         fl.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_len();
    test_busy_held();
    test_all_four();
    test_full();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
